// File: rtl/br_predict_unit.sv
// Branch resolution (EX) and 2-bit saturating-counter direction predictor (IF).
// Optional macro BR_STATS_EN adds saturating branch / mispredict statistics counters.
module br_predict_unit #(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned FLAG_W   = 4,
  parameter logic [1:0]  CNT_INIT = 2'b01,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   pc_IF,
  output logic              pred_taken_IF,
  input  logic [PC_W-1:0]   pc_ID_EX,
  input  logic              pred_taken_ID_EX,
  input  logic              br_instr_ID_EX,
  input  logic              jmp_imm_ID_EX,
  input  logic              jmp_reg_ID_EX,
  input  logic              rti_ID_EX,
  input  logic [2:0]        cc_ID_EX,
  input  logic [FLAG_W-1:0] PSW,
  input  logic              flush_ID_EX,
  output logic              flow_change_ID_EX,
  output logic              mispredict_EX
`ifdef BR_STATS_EN
  , output logic [STAT_W-1:0] br_count
  , output logic [STAT_W-1:0] mispred_count
`endif
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0]       cnt_q [DEPTH];
  logic [1:0]       cnt_d [DEPTH];
  logic             taken;
  logic             upd;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       cur_cnt;
  logic             flag_z, flag_n, flag_v;
  logic             unused_bits;

  assign flag_z = PSW[0];
  assign flag_n = PSW[1];
  assign flag_v = PSW[2];
  // Only the low PC bits index the table and only Z/N/V are read.
  assign unused_bits = ^{PSW, pc_IF, pc_ID_EX, STAT_W[0]};

  always_comb begin
    taken = 1'b0;
    case (cc_ID_EX)
      3'b000:  taken = ~flag_z;
      3'b001:  taken = flag_z;
      3'b010:  taken = ~flag_z & ~flag_n;
      3'b011:  taken = flag_n;
      3'b100:  taken = flag_z | ~flag_n;
      3'b101:  taken = flag_n | flag_z;
      3'b110:  taken = flag_v;
      default: taken = 1'b1;
    endcase
  end

  always_comb begin
    flow_change_ID_EX = 1'b0;
    if (!flush_ID_EX) begin
      if (br_instr_ID_EX) flow_change_ID_EX = taken;
      else                flow_change_ID_EX = jmp_imm_ID_EX | jmp_reg_ID_EX | rti_ID_EX;
    end
  end

  assign mispredict_EX = ~flush_ID_EX & br_instr_ID_EX & (taken != pred_taken_ID_EX);
  assign pred_taken_IF = cnt_q[pc_IF[IDX_W-1:0]][1];

  assign upd     = br_instr_ID_EX & ~flush_ID_EX & (cc_ID_EX != 3'b111);
  assign upd_idx = pc_ID_EX[IDX_W-1:0];
  assign cur_cnt = cnt_q[upd_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (upd) begin
      if (taken && cur_cnt != 2'b11)       cnt_d[upd_idx] = cur_cnt + 2'b01;
      else if (!taken && cur_cnt != 2'b00) cnt_d[upd_idx] = cur_cnt - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef BR_STATS_EN
  logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
  logic [STAT_W-1:0] mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (upd && br_cnt_q != '1)           br_cnt_d = br_cnt_q + 1'b1;
    if (mispredict_EX && mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mp_cnt_q;
`endif

endmodule

// File: tb/tb_br_predict_unit.sv
// Directed self-checking bench for br_predict_unit (BR_STATS_EN section only when defined).
module tb_br_predict_unit;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PC_W-1:0]   pc_IF;
  logic              pred_taken_IF;
  logic [PC_W-1:0]   pc_ID_EX;
  logic              pred_taken_ID_EX;
  logic              br_instr_ID_EX;
  logic              jmp_imm_ID_EX;
  logic              jmp_reg_ID_EX;
  logic              rti_ID_EX;
  logic [2:0]        cc_ID_EX;
  logic [FLAG_W-1:0] PSW;
  logic              flush_ID_EX;
  logic              flow_change_ID_EX;
  logic              mispredict_EX;
`ifdef BR_STATS_EN
  logic [STAT_W-1:0] br_count;
  logic [STAT_W-1:0] mispred_count;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  br_predict_unit #(
    .PC_W    (PC_W),
    .IDX_W   (IDX_W),
    .FLAG_W  (FLAG_W),
    .CNT_INIT(2'b01),
    .STAT_W  (STAT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_IF            (pc_IF),
    .pred_taken_IF    (pred_taken_IF),
    .pc_ID_EX         (pc_ID_EX),
    .pred_taken_ID_EX (pred_taken_ID_EX),
    .br_instr_ID_EX   (br_instr_ID_EX),
    .jmp_imm_ID_EX    (jmp_imm_ID_EX),
    .jmp_reg_ID_EX    (jmp_reg_ID_EX),
    .rti_ID_EX        (rti_ID_EX),
    .cc_ID_EX         (cc_ID_EX),
    .PSW              (PSW),
    .flush_ID_EX      (flush_ID_EX),
    .flow_change_ID_EX(flow_change_ID_EX),
    .mispredict_EX    (mispredict_EX)
`ifdef BR_STATS_EN
    , .br_count       (br_count)
    , .mispred_count  (mispred_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_instr_ID_EX   = 1'b0;
    jmp_imm_ID_EX    = 1'b0;
    jmp_reg_ID_EX    = 1'b0;
    rti_ID_EX        = 1'b0;
    flush_ID_EX      = 1'b0;
    pred_taken_ID_EX = 1'b0;
    cc_ID_EX         = 3'b000;
    PSW              = '0;
    pc_ID_EX         = '0;
  endtask

  // {cc, PSW, expected taken}
  typedef struct packed {
    logic [2:0] cc;
    logic [3:0] psw;
    logic       exp;
  } cond_vec_t;

  cond_vec_t cond_tbl [15] = '{
    '{3'b000, 4'b0000, 1'b1}, '{3'b000, 4'b0001, 1'b0},
    '{3'b001, 4'b0001, 1'b1}, '{3'b001, 4'b0000, 1'b0},
    '{3'b010, 4'b0000, 1'b1}, '{3'b010, 4'b0010, 1'b0},
    '{3'b011, 4'b0010, 1'b1}, '{3'b011, 4'b0000, 1'b0},
    '{3'b100, 4'b0000, 1'b1}, '{3'b100, 4'b0010, 1'b0},
    '{3'b100, 4'b0011, 1'b1}, '{3'b101, 4'b0000, 1'b0},
    '{3'b101, 4'b0001, 1'b1}, '{3'b110, 4'b0100, 1'b1},
    '{3'b110, 4'b1011, 1'b0}
  };

  // Predictions after 4 taken then 5 not-taken updates from weak-NT:
  // counters 10,11,11,11,10,01,00,00,00
  logic pred_seq [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0;
    pc_IF = '0;
    idle();
    #1;
    check("pred_in_reset", 32'(pred_taken_IF), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 64; i++) begin
      pc_IF = PC_W'(i);
      #1;
      check($sformatf("reset_pred_%0d", i), 32'(pred_taken_IF), 32'd0);
    end

    for (int i = 0; i < 15; i++) begin
      br_instr_ID_EX = 1'b1;
      cc_ID_EX = cond_tbl[i].cc;
      PSW = cond_tbl[i].psw;
      #1;
      check($sformatf("cond_%0d", i), 32'(flow_change_ID_EX), 32'(cond_tbl[i].exp));
      check($sformatf("cond_mp_%0d", i), 32'(mispredict_EX), 32'(cond_tbl[i].exp));
    end
    idle();
    step();

    // cc=001 taken, predicted not-taken, index 5
    br_instr_ID_EX = 1'b1; cc_ID_EX = 3'b001; PSW = 4'b0001; pc_ID_EX = 16'h0005;
    pc_IF = 16'h0005;
    #1;
    check("br5_flow", 32'(flow_change_ID_EX), 32'd1);
    check("br5_mispred", 32'(mispredict_EX), 32'd1);
    check("br5_pre_update", 32'(pred_taken_IF), 32'd0);
    step();
    idle();
    #1;
    check("br5_post_update", 32'(pred_taken_IF), 32'd1);
    pc_IF = 16'h0045;
    #1;
    check("alias_0x45", 32'(pred_taken_IF), 32'd1);

    pc_IF = 16'h0003;
    for (int i = 0; i < 9; i++) begin
      br_instr_ID_EX = 1'b1; cc_ID_EX = 3'b000; pc_ID_EX = 16'h0003;
      PSW = (i < 4) ? 4'b0000 : 4'b0001;
      step();
      idle();
      #1;
      check($sformatf("idx3_seq_%0d", i), 32'(pred_taken_IF), 32'(pred_seq[i]));
    end

    // Unconditional branch, jmp_reg, rti at index 7: no table update
    pc_IF = 16'h0007;
    for (int i = 0; i < 3; i++) begin
      idle();
      PSW = 4'($urandom);
      pc_ID_EX = 16'h0007;
      pred_taken_ID_EX = 1'b1;
      case (i)
        0: begin br_instr_ID_EX = 1'b1; cc_ID_EX = 3'b111; end
        1: jmp_reg_ID_EX = 1'b1;
        default: rti_ID_EX = 1'b1;
      endcase
      #1;
      check($sformatf("uncond_flow_%0d", i), 32'(flow_change_ID_EX), 32'd1);
      check($sformatf("uncond_mp_%0d", i), 32'(mispredict_EX), 32'd0);
      step();
      idle();
      #1;
      check($sformatf("uncond_tbl_%0d", i), 32'(pred_taken_IF), 32'd0);
    end
    jmp_imm_ID_EX = 1'b1;
    #1;
    check("jmp_imm_flow", 32'(flow_change_ID_EX), 32'd1);
    idle();

    // Flushed taken branch at index 9
    pc_IF = 16'h0009;
    br_instr_ID_EX = 1'b1; cc_ID_EX = 3'b000; PSW = 4'b0000; pc_ID_EX = 16'h0009;
    flush_ID_EX = 1'b1;
    #1;
    check("flush_flow", 32'(flow_change_ID_EX), 32'd0);
    check("flush_mp", 32'(mispredict_EX), 32'd0);
    step();
    idle();
    #1;
    check("flush_tbl", 32'(pred_taken_IF), 32'd0);

    // Same-cycle read and write of index 37
    pc_IF = 16'h0025;
    br_instr_ID_EX = 1'b1; cc_ID_EX = 3'b000; PSW = 4'b0000; pc_ID_EX = 16'h0025;
    @(negedge clk);
    check("rw_same_old", 32'(pred_taken_IF), 32'd0);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("rw_same_new", 32'(pred_taken_IF), 32'd1);

    // Asynchronous reset mid-cycle with an update pending
    br_instr_ID_EX = 1'b1; cc_ID_EX = 3'b000; PSW = 4'b0000; pc_ID_EX = 16'h0025;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_37", 32'(pred_taken_IF), 32'd0);
    pc_IF = 16'h0005;
    #1;
    check("async_rst_5", 32'(pred_taken_IF), 32'd0);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    pc_IF = 16'h0025;
    step();
    check("after_rst_37", 32'(pred_taken_IF), 32'd0);

`ifdef BR_STATS_EN
    check("stats_rst_br", 32'(br_count), 32'd0);
    check("stats_rst_mp", 32'(mispred_count), 32'd0);
    for (int i = 0; i < 17; i++) begin
      br_instr_ID_EX = 1'b1; cc_ID_EX = 3'b000; PSW = 4'b0000;
      pc_ID_EX = 16'h000B; pred_taken_ID_EX = 1'b0;
      step();
    end
    idle();
    #1;
    check("stats_sat_br", 32'(br_count), 32'd15);
    check("stats_sat_mp", 32'(mispred_count), 32'd15);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("stats_async_br", 32'(br_count), 32'd0);
    check("stats_async_mp", 32'(mispred_count), 32'd0);
    step();
    rst_n = 1'b1;
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
